// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with load, wrap/saturate mode, cascade carry and wrap/load-error flags.
// Define MODN_BCD_OUT_EN to add a registered BCD image of the count on port bcd.
module modn_updown_counter #(
  parameter int MODULUS  = 100,
  parameter int WIDTH    = 7,
  parameter int SATURATE = 0
`ifdef MODN_BCD_OUT_EN
  ,
  localparam int BCD_D = ((MODULUS - 1) < 10)         ? 1 :
                         ((MODULUS - 1) < 100)        ? 2 :
                         ((MODULUS - 1) < 1000)       ? 3 :
                         ((MODULUS - 1) < 10000)      ? 4 :
                         ((MODULUS - 1) < 100000)     ? 5 :
                         ((MODULUS - 1) < 1000000)    ? 6 :
                         ((MODULUS - 1) < 10000000)   ? 7 :
                         ((MODULUS - 1) < 100000000)  ? 8 :
                         ((MODULUS - 1) < 1000000000) ? 9 : 10
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
`ifdef MODN_BCD_OUT_EN
  ,
  output logic [4*BCD_D-1:0] bcd
`endif
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

  generate
    if (MODULUS < 2 || (64'd1 << WIDTH) < 64'(MODULUS)) begin : g_param_chk
      $error("modn_updown_counter: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             at_top, at_bot, load_ok;

  // The +1 only happens below MAX_C, so it can never reach 2**WIDTH.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c);
    if (c == MAX_C) return (SATURATE != 0) ? c : '0;
    return c + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] c);
    if (c == '0) return (SATURATE != 0) ? c : MAX_C;
    return c - WIDTH'(1);
  endfunction

  assign at_top  = (count_q == MAX_C);
  assign at_bot  = (count_q == '0);
  assign load_ok = ({1'b0, load_val} < MOD_X);

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (up_dn) begin
        count_d = step_up(count_q);
        wrap_d  = (SATURATE == 0) && at_top;
      end else begin
        count_d = step_down(count_q);
        wrap_d  = (SATURATE == 0) && at_bot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  // Carry/borrow is asserted in saturate mode too so cascades still chain.
  assign tc       = en & ((up_dn & at_top) | (~up_dn & at_bot));

`ifdef MODN_BCD_OUT_EN
  logic [4*BCD_D-1:0] bcd_q;

  // Double-dabble; intermediate prefixes never exceed the count, so BCD_D digits suffice.
  function automatic logic [4*BCD_D-1:0] to_bcd(input logic [WIDTH-1:0] bin);
    logic [4*BCD_D+WIDTH-1:0] sh;
    sh = '0;
    sh[WIDTH-1:0] = bin;
    for (int i = 0; i < WIDTH; i++) begin
      for (int k = 0; k < BCD_D; k++) begin
        if (sh[WIDTH+4*k +: 4] >= 4'd5)
          sh[WIDTH+4*k +: 4] = sh[WIDTH+4*k +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[WIDTH +: 4*BCD_D];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bcd_q <= '0;
    else     bcd_q <= to_bcd(count_d);
  end

  assign bcd = bcd_q;
`endif

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed self-checking bench: wrap, saturate, load, async reset and two-stage cascade.
module tb_modn_updown_counter;

  logic clk;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic       d_rst, d_en, d_up, d_load, d_tc, d_wrap, d_lerr;
  logic [6:0] d_lv, d_cnt;
  logic       s_rst, s_en, s_up, s_load, s_tc, s_wrap, s_lerr;
  logic [6:0] s_lv, s_cnt;
  logic       c_rst, c_en, u_load, u_tc, u_wrap, u_lerr, t_tc, t_wrap, t_lerr;
  logic [6:0] u_lv, u_cnt, t_cnt;
  logic       c_up = 1'b1;
  logic       t_load = 1'b0;
  logic [6:0] t_lv = 7'd0;
`ifdef MODN_BCD_OUT_EN
  logic [7:0] d_bcd, s_bcd, u_bcd, t_bcd;
`endif

  modn_updown_counter #(.MODULUS(100), .WIDTH(7), .SATURATE(0)) u_dut (
    .clk(clk), .rst(d_rst), .en(d_en), .up_dn(d_up), .load(d_load), .load_val(d_lv),
    .count(d_cnt), .tc(d_tc), .wrap(d_wrap), .load_err(d_lerr)
`ifdef MODN_BCD_OUT_EN
    , .bcd(d_bcd)
`endif
  );

  modn_updown_counter #(.MODULUS(100), .WIDTH(7), .SATURATE(1)) u_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .up_dn(s_up), .load(s_load), .load_val(s_lv),
    .count(s_cnt), .tc(s_tc), .wrap(s_wrap), .load_err(s_lerr)
`ifdef MODN_BCD_OUT_EN
    , .bcd(s_bcd)
`endif
  );

  modn_updown_counter #(.MODULUS(100), .WIDTH(7), .SATURATE(0)) u_units (
    .clk(clk), .rst(c_rst), .en(c_en), .up_dn(c_up), .load(u_load), .load_val(u_lv),
    .count(u_cnt), .tc(u_tc), .wrap(u_wrap), .load_err(u_lerr)
`ifdef MODN_BCD_OUT_EN
    , .bcd(u_bcd)
`endif
  );

  modn_updown_counter #(.MODULUS(100), .WIDTH(7), .SATURATE(0)) u_tens (
    .clk(clk), .rst(c_rst), .en(u_tc), .up_dn(c_up), .load(t_load), .load_val(t_lv),
    .count(t_cnt), .tc(t_tc), .wrap(t_wrap), .load_err(t_lerr)
`ifdef MODN_BCD_OUT_EN
    , .bcd(t_bcd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d_rst = 1; d_en = 0; d_up = 1; d_load = 0; d_lv = 0;
    s_rst = 1; s_en = 0; s_up = 1; s_load = 0; s_lv = 0;
    c_rst = 1; c_en = 0; u_load = 0; u_lv = 0;
    repeat (2) tick();
    chk("rst_cnt",  32'(d_cnt), 0);
    chk("rst_wrap", 32'(d_wrap), 0);
    chk("rst_lerr", 32'(d_lerr), 0);
    chk("rst_sat",  32'(s_cnt), 0);
    d_rst = 0; s_rst = 0; c_rst = 0;

    // Up count and wrap
    d_en = 1; d_up = 1;
    repeat (98) tick();
    chk("up_98", 32'(d_cnt), 98);
    chk("tc_98", 32'(d_tc), 0);
    tick();
    chk("up_99",   32'(d_cnt), 99);
    chk("tc_99",   32'(d_tc), 1);
    chk("wrap_99", 32'(d_wrap), 0);
    tick();
    chk("up_wrap_cnt", 32'(d_cnt), 0);
    chk("up_wrap",     32'(d_wrap), 1);
    tick();
    chk("up_after_cnt",  32'(d_cnt), 1);
    chk("up_after_wrap", 32'(d_wrap), 0);

    // Async reset mid-count, with a pending load error
    d_en = 0; d_load = 1; d_lv = 37;
    tick();
    chk("ld_37", 32'(d_cnt), 37);
    d_lv = 120;
    tick();
    chk("ld_bad_cnt",  32'(d_cnt), 37);
    chk("ld_bad_lerr", 32'(d_lerr), 1);
    d_load = 0;
    #3 d_rst = 1;
    #1;
    chk("arst_cnt",  32'(d_cnt), 0);
    chk("arst_lerr", 32'(d_lerr), 0);
    chk("arst_wrap", 32'(d_wrap), 0);
    d_en = 1; d_up = 1;
    tick();
    chk("arst_hold", 32'(d_cnt), 0);
    d_rst = 0;
    tick();
    chk("arst_resume", 32'(d_cnt), 1);

    // Down wrap
    d_en = 0; d_load = 1; d_lv = 0;
    tick();
    d_load = 0;
    chk("ld_0", 32'(d_cnt), 0);
    d_en = 1; d_up = 0;
    #1;
    chk("tc_dn_0", 32'(d_tc), 1);
    tick();
    chk("dn_wrap_cnt", 32'(d_cnt), 99);
    chk("dn_wrap",     32'(d_wrap), 1);
    tick();
    chk("dn_98",      32'(d_cnt), 98);
    chk("dn_98_wrap", 32'(d_wrap), 0);

    // Load priority and range checks
    d_up = 1; d_en = 1; d_load = 1; d_lv = 42;
    tick();
    chk("ld_42",      32'(d_cnt), 42);
    chk("ld_42_lerr", 32'(d_lerr), 0);
    d_lv = 120;
    tick();
    chk("ld_120_cnt",  32'(d_cnt), 42);
    chk("ld_120_lerr", 32'(d_lerr), 1);
    d_load = 0; d_en = 0;
    tick();
    chk("ld_hold_cnt",  32'(d_cnt), 42);
    chk("ld_lerr_drop", 32'(d_lerr), 0);
    d_load = 1; d_lv = 99;
    tick();
    chk("ld_99",      32'(d_cnt), 99);
    chk("ld_99_lerr", 32'(d_lerr), 0);
    d_lv = 100;
    tick();
    chk("ld_100_cnt",  32'(d_cnt), 99);
    chk("ld_100_lerr", 32'(d_lerr), 1);
    d_load = 0;
    tick();
    chk("hold_99",    32'(d_cnt), 99);
    chk("hold_tc_en0", 32'(d_tc), 0);

    // Saturating instance
    s_en = 1; s_up = 1;
    repeat (99) tick();
    chk("sat_99",    32'(s_cnt), 99);
    chk("sat_tc_99", 32'(s_tc), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_hold_cnt",  32'(s_cnt), 99);
      chk("sat_hold_wrap", 32'(s_wrap), 0);
    end
    chk("sat_hold_tc", 32'(s_tc), 1);
    s_up = 0;
    tick();
    chk("sat_flip_98", 32'(s_cnt), 98);
    s_load = 1; s_lv = 0;
    tick();
    s_load = 0;
    #1;
    chk("sat_tc_dn", 32'(s_tc), 1);
    tick();
    chk("sat_dn_hold", 32'(s_cnt), 0);
    chk("sat_dn_wrap", 32'(s_wrap), 0);

    // Two-stage cascade 0..9999
    c_en = 1;
    repeat (99) tick();
    chk("cas_u_99", 32'(u_cnt), 99);
    chk("cas_t_0",  32'(t_cnt), 0);
    chk("cas_utc",  32'(u_tc), 1);
    tick();
    chk("cas_u_0", 32'(u_cnt), 0);
    chk("cas_t_1", 32'(t_cnt), 1);
    repeat (9899) tick();
    chk("cas_9999_u", 32'(u_cnt), 99);
    chk("cas_9999_t", 32'(t_cnt), 99);
    chk("cas_9999_ttc", 32'(t_tc), 1);
    tick();
    chk("cas_roll_u", 32'(u_cnt), 0);
    chk("cas_roll_t", 32'(t_cnt), 0);
    chk("cas_roll_twrap", 32'(t_wrap), 1);
    c_en = 0; u_load = 1; u_lv = 57;
    tick();
    u_load = 0;
    chk("cas_ld_57", 32'(u_cnt), 57);
    chk("cas_ld_t",  32'(t_cnt), 0);
`ifdef MODN_BCD_OUT_EN
    chk("bcd_57", 32'(u_bcd), 32'h57);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
